// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forwarding select encoding, MDU tracking states and
// the default register-index width.
package hazard_pkg;

   localparam int unsigned REG_W_DEFAULT = 5;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_t;

endpackage

// File: rtl/mdu_scoreboard.sv
// Tracks the single in-flight non-blocking MDU op: IDLE/BUSY FSM, per-GPR and HI/LO busy
// bits, and the D-stage scoreboard stall term.
module mdu_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned REG_W = REG_W_DEFAULT,
   parameter int unsigned NREG  = 2 ** REG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] rsD,
   input  logic [REG_W-1:0] rtD,
   input  logic [REG_W-1:0] writeregD,
   input  logic             hiloreadD,
   input  logic             mdustartD,
   input  logic [REG_W-1:0] writeregE,
   input  logic             mdustartE,
   input  logic             mdu_gprE,
   input  logic             mdu_done,
   input  logic             excM,
   output logic             mdu_busy,
   output logic             sb
);

   mdu_state_t       state_q, state_d;
   logic [NREG-1:0]  busyGpr_q, busyGpr_d;
   logic             busyHilo_q, busyHilo_d;
   logic [REG_W-1:0] dest_q, dest_d;
   logic             selGpr_q, selGpr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         busyGpr_q  <= '0;
         busyHilo_q <= 1'b0;
         dest_q     <= '0;
         selGpr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         busyGpr_q  <= busyGpr_d;
         busyHilo_q <= busyHilo_d;
         dest_q     <= dest_d;
         selGpr_q   <= selGpr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      busyGpr_d  = busyGpr_q;
      busyHilo_d = busyHilo_q;
      dest_d     = dest_q;
      selGpr_d   = selGpr_q;
      case (state_q)
         IDLE: begin
            // An excepting M-stage instruction kills the younger op trying to issue from E.
            if (mdustartE && !excM) begin
               state_d  = BUSY;
               dest_d   = writeregE;
               selGpr_d = mdu_gprE && (writeregE != '0);
               if (selGpr_d) busyGpr_d[writeregE] = 1'b1;
               else          busyHilo_d           = 1'b1;
            end
         end
         BUSY: begin
            if (mdu_done) begin
               state_d = IDLE;
               if (selGpr_q) busyGpr_d[dest_q] = 1'b0;
               else          busyHilo_d        = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mdu_busy = (state_q == BUSY);
      sb       = 1'b0;
      if (state_q == BUSY) begin
         sb = ((rsD != '0) && busyGpr_q[rsD]) ||
              ((rtD != '0) && busyGpr_q[rtD]) ||
              (hiloreadD && busyHilo_q) ||
              mdustartD ||
              ((writeregD != '0) && busyGpr_q[writeregD]);
      end
   end

endmodule

// File: rtl/hazard_sb.sv
// 5-stage MIPS hazard unit with forwarding, load-use/branch/jr stalls, MDU scoreboard,
// exception flushes and a saturating stall-cycle counter.
module hazard_sb
   import hazard_pkg::*;
#(
   parameter int unsigned REG_W = REG_W_DEFAULT,
   parameter int unsigned NREG  = 2 ** REG_W,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] rsD,
   input  logic [REG_W-1:0] rtD,
   input  logic [REG_W-1:0] writeregD,
   input  logic             branchD,
   input  logic             jrD,
   input  logic             hiloreadD,
   input  logic             mdustartD,
   input  logic [REG_W-1:0] rsE,
   input  logic [REG_W-1:0] rtE,
   input  logic [REG_W-1:0] writeregE,
   input  logic             regwriteE,
   input  logic             memtoregE,
   input  logic             mdustartE,
   input  logic             mdu_gprE,
   input  logic [REG_W-1:0] writeregM,
   input  logic             regwriteM,
   input  logic             memtoregM,
   input  logic [REG_W-1:0] writeregW,
   input  logic             regwriteW,
   input  logic             mdu_done,
   input  logic             excM,
   input  logic             perf_clr,
   output logic             forwardaD,
   output logic             forwardbD,
   output logic [1:0]       forwardaE,
   output logic [1:0]       forwardbE,
   output logic             stallF,
   output logic             stallD,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             flushW,
   output logic             mdu_busy,
   output logic [CNT_W-1:0] stall_cycles
);

   fwd_sel_t   fwdaE, fwdbE;
   logic       lwStall, brStall, jrStall, sbStall, anyStall, stall;
   logic       eHitsD, mHitsD;
   logic [CNT_W-1:0] stallCnt_q;

   mdu_scoreboard #(
      .REG_W(REG_W),
      .NREG (NREG)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .rsD      (rsD),
      .rtD      (rtD),
      .writeregD(writeregD),
      .hiloreadD(hiloreadD),
      .mdustartD(mdustartD),
      .writeregE(writeregE),
      .mdustartE(mdustartE),
      .mdu_gprE (mdu_gprE),
      .mdu_done (mdu_done),
      .excM     (excM),
      .mdu_busy (mdu_busy),
      .sb       (sbStall)
   );

   always_comb begin
      forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
      forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

      fwdaE = FWD_RF;
      if ((rsE != '0) && (rsE == writeregM) && regwriteM)      fwdaE = FWD_M;
      else if ((rsE != '0) && (rsE == writeregW) && regwriteW) fwdaE = FWD_W;

      fwdbE = FWD_RF;
      if ((rtE != '0) && (rtE == writeregM) && regwriteM)      fwdbE = FWD_M;
      else if ((rtE != '0) && (rtE == writeregW) && regwriteW) fwdbE = FWD_W;

      forwardaE = fwdaE;
      forwardbE = fwdbE;
   end

   always_comb begin
      eHitsD   = (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
      mHitsD   = (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD));
      lwStall  = memtoregE && eHitsD;
      brStall  = branchD && ((regwriteE && eHitsD) || (memtoregM && mHitsD));
      jrStall  = jrD && ((regwriteE && eHitsD) || (memtoregM && mHitsD));
      anyStall = lwStall || brStall || jrStall || sbStall;
      // The exception flush wins: stalling D/F would hold the faulting path in the pipe.
      stall    = anyStall && !excM;
      stallF   = stall;
      stallD   = stall;
      flushE   = anyStall || excM;
      flushD   = excM;
      flushM   = excM;
      flushW   = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             stallCnt_q <= '0;
      else if (perf_clr)                   stallCnt_q <= '0;
      else if (stall && stallCnt_q != '1)  stallCnt_q <= stallCnt_q + CNT_W'(1);
   end

   assign stall_cycles = stallCnt_q;

endmodule

// File: tb/tb_hazard_sb.sv
// Self-checking bench for hazard_sb: directed test-plan cases then randomized traffic,
// all compared against a pending-op behavioural model.
module tb_hazard_sb;

   localparam int CNT_W  = 4;
   localparam int CNTMAX = (1 << CNT_W) - 1;

   logic clk, rst;
   logic [4:0] rsD, rtD, writeregD, rsE, rtE, writeregE, writeregM, writeregW;
   logic branchD, jrD, hiloreadD, mdustartD, regwriteE, memtoregE, mdustartE, mdu_gprE;
   logic regwriteM, memtoregM, regwriteW, mdu_done, excM, perf_clr;
   logic forwardaD, forwardbD, stallF, stallD, flushD, flushE, flushM, flushW, mdu_busy;
   logic [1:0] forwardaE, forwardbE;
   logic [CNT_W-1:0] stall_cycles;

   int checks = 0;
   int errors = 0;

   // Model: at most one pending MDU op, described by its destination kind and register.
   bit pendValid, pendGpr;
   int pendReg;
   int cnt;

   hazard_sb #(
      .REG_W(5),
      .NREG (32),
      .CNT_W(CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rsD         (rsD),
      .rtD         (rtD),
      .writeregD   (writeregD),
      .branchD     (branchD),
      .jrD         (jrD),
      .hiloreadD   (hiloreadD),
      .mdustartD   (mdustartD),
      .rsE         (rsE),
      .rtE         (rtE),
      .writeregE   (writeregE),
      .regwriteE   (regwriteE),
      .memtoregE   (memtoregE),
      .mdustartE   (mdustartE),
      .mdu_gprE    (mdu_gprE),
      .writeregM   (writeregM),
      .regwriteM   (regwriteM),
      .memtoregM   (memtoregM),
      .writeregW   (writeregW),
      .regwriteW   (regwriteW),
      .mdu_done    (mdu_done),
      .excM        (excM),
      .perf_clr    (perf_clr),
      .forwardaD   (forwardaD),
      .forwardbD   (forwardbD),
      .forwardaE   (forwardaE),
      .forwardbE   (forwardbE),
      .stallF      (stallF),
      .stallD      (stallD),
      .flushD      (flushD),
      .flushE      (flushE),
      .flushM      (flushM),
      .flushW      (flushW),
      .mdu_busy    (mdu_busy),
      .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic clearIn();
      {rsD, rtD, writeregD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
      {branchD, jrD, hiloreadD, mdustartD, regwriteE, memtoregE, mdustartE, mdu_gprE} = '0;
      {regwriteM, memtoregM, regwriteW, mdu_done, excM, perf_clr} = '0;
   endtask

   function automatic int fwdE(input logic [4:0] src);
      if (src != 0 && src == writeregM && regwriteM) return 2;
      if (src != 0 && src == writeregW && regwriteW) return 1;
      return 0;
   endfunction

   function automatic bit readsD(input int r);
      return r != 0 && (int'(rsD) == r || int'(rtD) == r);
   endfunction

   // Compare every output at the negedge, then advance the model at the posedge.
   task automatic step();
      int  expFwd;
      bit  lw, br, jr, sb, hz, stl;
      if (rst) begin
         pendValid = 0;
         cnt       = 0;
      end
      @(negedge clk);
      expFwd = (int'(rsD != 0 && rsD == writeregM && regwriteM) << 5) |
               (int'(rtD != 0 && rtD == writeregM && regwriteM) << 4) |
               (fwdE(rsE) << 2) | fwdE(rtE);
      lw  = memtoregE && readsD(int'(writeregE));
      br  = branchD && ((regwriteE && readsD(int'(writeregE))) ||
                        (memtoregM && readsD(int'(writeregM))));
      jr  = jrD && ((regwriteE && readsD(int'(writeregE))) ||
                    (memtoregM && readsD(int'(writeregM))));
      sb  = pendValid && (mdustartD || (!pendGpr && hiloreadD) ||
                          (pendGpr && (readsD(pendReg) || int'(writeregD) == pendReg)));
      hz  = lw || br || jr || sb;
      stl = hz && !excM;
      chk("fwd", 32'({forwardaD, forwardbD, forwardaE, forwardbE}), 32'(expFwd));
      chk("stall", 32'({stallF, stallD}), 32'({stl, stl}));
      chk("flush", 32'({flushD, flushE, flushM, flushW}), 32'({excM, hz || excM, excM, 1'b0}));
      chk("busy", 32'(mdu_busy), 32'(pendValid));
      chk("cnt", 32'(stall_cycles), 32'(cnt));
      @(posedge clk);
      if (!rst) begin
         if (!pendValid && mdustartE && !excM) begin
            pendValid = 1;
            pendGpr   = mdu_gprE && writeregE != 0;
            pendReg   = int'(writeregE);
         end else if (pendValid && mdu_done) begin
            pendValid = 0;
         end
         if (perf_clr)                 cnt = 0;
         else if (stl && cnt < CNTMAX) cnt = cnt + 1;
      end
      #1;
   endtask

   function automatic logic [4:0] rreg();
      return 5'($urandom_range(0, 7));
   endfunction

   function automatic logic pick(input int n);
      return 1'($urandom_range(0, n - 1) == 0);
   endfunction

   initial begin
      pendValid = 0; pendGpr = 0; pendReg = 0; cnt = 0;
      clearIn();
      rst = 1'b1;
      #1;
      chk("rst_busy", 32'(mdu_busy), 32'd0);
      chk("rst_cnt", 32'(stall_cycles), 32'd0);
      step();
      rst = 1'b0;
      step();

      // Forwarding priority and $0 suppression.
      writeregM = 5'd3; regwriteM = 1'b1; rsE = 5'd3;
      #2 chk("fwd_m", 32'(forwardaE), 32'd2);
      step();
      writeregW = 5'd3; regwriteW = 1'b1;
      #2 chk("fwd_m_over_w", 32'(forwardaE), 32'd2);
      step();
      writeregM = 5'd0; rsE = 5'd0; writeregW = 5'd0;
      #2 chk("fwd_zero", 32'(forwardaE), 32'd0);
      step();

      // Load-use stall for exactly one cycle.
      clearIn();
      memtoregE = 1'b1; writeregE = 5'd5; rtD = 5'd5;
      #2 chk("lw_stall", 32'({stallD, stallF, flushE}), 32'b111);
      step();
      clearIn();
      #2 chk("lw_release", 32'({stallD, stallF, flushE}), 32'b000);
      step();

      // mult to HI/LO, then mfhi waits until the cycle after mdu_done.
      mdustartE = 1'b1;
      step();
      clearIn();
      hiloreadD = 1'b1;
      #2 chk("mfhi_stall", 32'({mdu_busy, stallD}), 32'b11);
      repeat (3) step();
      mdu_done = 1'b1;
      #2 chk("mfhi_done_stall", 32'(stallD), 32'd1);
      step();
      mdu_done = 1'b0;
      #2 chk("mfhi_release", 32'({mdu_busy, stallD}), 32'b00);
      step();

      // mul $7: RAW on 7 stalls, 8 does not, WAW on 7 stalls.
      clearIn();
      mdustartE = 1'b1; mdu_gprE = 1'b1; writeregE = 5'd7;
      step();
      clearIn();
      rsD = 5'd7;
      #2 chk("raw7", 32'(stallD), 32'd1);
      step();
      rsD = 5'd8;
      #2 chk("raw8", 32'(stallD), 32'd0);
      step();
      rsD = 5'd0; writeregD = 5'd7;
      #2 chk("waw7", 32'(stallD), 32'd1);
      step();
      clearIn();
      mdu_done = 1'b1;
      step();
      clearIn();

      // Exception at issue: op is dropped, flushes fire, no stall.
      excM = 1'b1; mdustartE = 1'b1;
      #2 chk("exc_flush", 32'({flushD, flushE, flushM, stallD}), 32'b1110);
      step();
      clearIn();
      #2 chk("exc_idle", 32'(mdu_busy), 32'd0);
      step();

      // Counter saturation and clear.
      perf_clr = 1'b1;
      step();
      clearIn();
      memtoregE = 1'b1; writeregE = 5'd5; rsD = 5'd5;
      repeat (CNTMAX - 1) step();
      chk("cnt_pre", 32'(stall_cycles), 32'(CNTMAX - 1));
      repeat (3) step();
      chk("cnt_sat", 32'(stall_cycles), 32'(CNTMAX));
      perf_clr = 1'b1;
      step();
      chk("cnt_clr", 32'(stall_cycles), 32'd0);

      // Reset asserted mid-BUSY drops tracking at once.
      clearIn();
      mdustartE = 1'b1; mdu_gprE = 1'b1; writeregE = 5'd4;
      step();
      clearIn();
      #2 chk("busy_before_rst", 32'(mdu_busy), 32'd1);
      rst = 1'b1;
      #1 chk("rst_mid_busy", 32'(mdu_busy), 32'd0);
      step();
      rst = 1'b0;
      step();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rsD = rreg(); rtD = rreg(); writeregD = rreg();
         branchD = pick(4); jrD = pick(8); hiloreadD = pick(3); mdustartD = pick(8);
         rsE = rreg(); rtE = rreg(); writeregE = rreg();
         regwriteE = pick(2); memtoregE = pick(4); mdustartE = pick(4); mdu_gprE = pick(2);
         writeregM = rreg(); regwriteM = pick(2); memtoregM = pick(4);
         writeregW = rreg(); regwriteW = pick(2);
         mdu_done = pick(4); excM = pick(16); perf_clr = pick(64); rst = pick(128);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
